vl_onehot_rr_arbiter: RTL

- Round-robin arbiter that shares one resource among `width` requesters.
- Issues a registered one-hot grant and locks it to the owner until the owner signals `done`.
- Continuously checks its own grant vector with population-count one-hot semantics and raises a sticky error on violation.
- Placed in front of any shared datapath that VL-generated designs arbitrate, e.g. a shared memory port or bus.

---
 rtl/vl_onehot_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vl_onehot_rr_arbiter.sv
// Round-robin arbiter with a locked one-hot grant.
// The grant is held until the owner pulses done. A one-idle-cycle bubble always
// separates two grants. A sticky flag records any inconsistency in the driven
// grant vector.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no owner; gnt is zero; arbitrate next requester from r_ptr
// S_GRANTED | gnt/owner locked to one requester until done is seen
module vl_onehot_rr_arbiter #(
  parameter int width = 4,
  localparam int OW = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] req,
  input  logic             done,
  output logic [width-1:0] gnt,
  output logic             gnt_valid,
  output logic [OW-1:0]    owner,
  output logic             onehot_err
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [width-1:0]   r_gnt;
  logic [width-1:0]   w_gnt_nxt;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      w_owner_nxt;
  logic [OW-1:0]      r_ptr;
  logic [OW-1:0]      w_ptr_nxt;
  logic               r_err;

  logic               w_found;
  logic [OW-1:0]      w_pick;
  logic [OW-1:0]      w_scan_idx;
  int                 w_sum;
  int                 w_count;
  logic               w_err_cond;

  // Scan requesters starting at r_ptr with wrap-around; the first one found wins.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    w_sum      = 0;
    for (int j = 0; j < width; j++) begin
      w_sum = int'(r_ptr) + j;
      if (w_sum >= width) w_sum = w_sum - width;
      w_scan_idx = OW'(w_sum);
      if (!w_found && req[w_scan_idx]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx;
      end
    end
  end

  // Next-state logic. The pointer moves only on a release, never on a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt         = S_GRANTED;
          w_gnt_nxt           = '0;
          w_gnt_nxt[w_pick]   = 1'b1;
          w_owner_nxt         = w_pick;
        end
      end
      S_GRANTED: begin
        if (done) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_owner_nxt = '0;
          if (r_owner == OW'(width - 1)) w_ptr_nxt = '0;
          else                           w_ptr_nxt = r_owner + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
      end
    endcase
  end

  // State, grant, owner and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Population count of the grant as actually driven on the output.
  // The check reads the port so that any corruption of it is caught.
  always_comb begin
    w_count = 0;
    for (int i = 0; i < width; i++) w_count = w_count + int'(gnt[i]);
    w_err_cond = (gnt_valid && (w_count != 1)) ||
                 (!gnt_valid && (w_count != 0)) ||
                 (gnt_valid && !gnt[owner]);
  end

  // Sticky consistency error; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_err_cond) r_err <= 1'b1;
  end

  assign gnt        = r_gnt;
  assign gnt_valid  = (r_state == S_GRANTED);
  assign owner      = r_owner;
  assign onehot_err = r_err;

endmodule
